// File: rtl/imem_arbiter_pkg.sv
// Shared constants, FSM state type and address helpers for the instruction-memory arbiter.
package imem_pkg;

  localparam int          IMEM_DEPTH = 128;
  localparam int          IMEM_AW    = 7;
  localparam logic [31:0] NOP_INSN   = 32'h00000013;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    LOAD  = 2'd2
  } state_e;

  // A fetch may touch the SRAM only if it is word aligned and inside the array.
  function automatic logic pc_in_range(input logic [63:0] pc, input int depth);
    return (pc[1:0] == 2'b00) && (pc < (64'(depth) * 64'd4));
  endfunction

endpackage

// File: rtl/imem_arbiter_if.sv
// Bundle of fetch, loader and SRAM signals; master = requestors plus SRAM, slave = arbiter.
interface imem_arbiter_if;
  import imem_pkg::*;

  logic               fetch_req_valid;
  logic               fetch_req_ready;
  logic [63:0]        fetch_pc;
  logic               fetch_flush;
  logic               fetch_rsp_valid;
  logic [31:0]        fetch_rsp_insn;
  logic               fetch_rsp_err;

  logic               ld_valid;
  logic               ld_ready;
  logic [IMEM_AW-1:0] ld_addr;
  logic [31:0]        ld_data;

  logic               mem_en;
  logic               mem_we;
  logic [IMEM_AW-1:0] mem_addr;
  logic [31:0]        mem_wdata;
  logic [31:0]        mem_rdata;

  modport master (
    output fetch_req_valid, fetch_pc, fetch_flush,
    output ld_valid, ld_addr, ld_data,
    output mem_rdata,
    input  fetch_req_ready, fetch_rsp_valid, fetch_rsp_insn, fetch_rsp_err,
    input  ld_ready,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  fetch_req_valid, fetch_pc, fetch_flush,
    input  ld_valid, ld_addr, ld_data,
    input  mem_rdata,
    output fetch_req_ready, fetch_rsp_valid, fetch_rsp_insn, fetch_rsp_err,
    output ld_ready,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/imem_arbiter_starve_ctr.sv
// Counts consecutive loader grants taken while a fetch is waiting; saturates at STARVE_LIMIT.
module imem_arb_starve_ctr
  import imem_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic fetch_valid_i,
  input  logic fetch_grant_i,
  input  logic ld_grant_i,
  output logic full_o
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (fetch_grant_i || !fetch_valid_i) begin
      cnt_d = '0;
    end else if (ld_grant_i && !full_o) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign full_o = (cnt_q == CW'(STARVE_LIMIT));

endmodule

// File: rtl/imem_arbiter.sv
// Arbitrates instruction fetches and loader writes onto one single-port SRAM.
// The loader path exists only when IMEM_ARB_LOADER_EN is defined; otherwise fetch owns the port.
module imem_arbiter
  import imem_pkg::*;
#(
  parameter int IMEM_DEPTH   = imem_pkg::IMEM_DEPTH,
  parameter int STARVE_LIMIT = 4
) (
  input logic           clk,
  input logic           rst_n,
  imem_arbiter_if.slave bus
);

  state_e             state_q, state_d;
  logic               err_q, err_d;
  logic [IMEM_AW-1:0] addr_q;
  logic [31:0]        wdata_q;

  logic pc_ok;
  logic fetch_ready;
  logic ld_ready;
  logic fetch_grant;
  logic ld_grant;
  logic fetch_access;
  logic rsp_live;

  assign pc_ok = pc_in_range(bus.fetch_pc, IMEM_DEPTH);

`ifdef IMEM_ARB_LOADER_EN
  logic starve_full;

  imem_arb_starve_ctr #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_starve (
    .clk           (clk),
    .rst_n         (rst_n),
    .fetch_valid_i (bus.fetch_req_valid),
    .fetch_grant_i (fetch_grant),
    .ld_grant_i    (ld_grant),
    .full_o        (starve_full)
  );

  // Loader has priority until the waiting fetch has been passed over STARVE_LIMIT times.
  assign fetch_ready = rst_n && (!bus.ld_valid || starve_full);
  assign ld_ready    = rst_n && (!bus.fetch_req_valid || !starve_full);
`else
  logic unused_limit;

  assign unused_limit = STARVE_LIMIT[0];
  assign fetch_ready  = rst_n;
  assign ld_ready     = 1'b0;
`endif

  assign fetch_grant  = bus.fetch_req_valid && fetch_ready;
  assign ld_grant     = bus.ld_valid && ld_ready;
  assign fetch_access = fetch_grant && pc_ok;

  assign bus.fetch_req_ready = fetch_ready;
  assign bus.ld_ready        = ld_ready;

  assign bus.mem_en    = ld_grant || fetch_access;
  assign bus.mem_we    = ld_grant;
  assign bus.mem_addr  = ld_grant     ? bus.ld_addr :
                         fetch_access ? bus.fetch_pc[IMEM_AW+1:2] :
                                        addr_q;
  assign bus.mem_wdata = ld_grant ? bus.ld_data : wdata_q;

  always_comb begin
    state_d = IDLE;
    err_d   = 1'b0;
    if (fetch_grant) begin
      state_d = FETCH;
      err_d   = !pc_ok;
    end else if (ld_grant) begin
      state_d = LOAD;
    end
  end

  // State always follows this cycle's grant; FETCH means a response is due next cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
    end
  end

  // Address and write data are plain datapath holds so idle cycles keep the SRAM pins steady.
  always_ff @(posedge clk) begin
    addr_q  <= bus.mem_addr;
    wdata_q <= bus.mem_wdata;
  end

  assign rsp_live = rst_n && (state_q == FETCH);

  assign bus.fetch_rsp_valid = rsp_live && !bus.fetch_flush;
  assign bus.fetch_rsp_err   = rsp_live && err_q;
  assign bus.fetch_rsp_insn  = !rsp_live ? 32'h0 :
                               err_q     ? NOP_INSN :
                                           bus.mem_rdata;

endmodule

// File: tb/tb_imem_arbiter.sv
// Self-checking bench for imem_arbiter: SRAM model plus a behavioural reference of grants and responses.
// Loader-specific steps are built only when IMEM_ARB_LOADER_EN is defined.
module tb_imem_arbiter;
  import imem_pkg::*;

  localparam int DEPTH = 128;
  localparam int LIMIT = 4;

`ifdef IMEM_ARB_LOADER_EN
  localparam bit LOADER = 1'b1;
`else
  localparam bit LOADER = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad   = 0;

  imem_arbiter_if bus ();

  imem_arbiter #(
    .IMEM_DEPTH   (DEPTH),
    .STARVE_LIMIT (LIMIT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] seedWord(input int i);
    if (i == 4) return 32'hDEADBEEF;
    return (32'(i) * 32'h9E3779B1) ^ 32'hA5A50000;
  endfunction

  // SRAM with one-cycle read latency, preloaded on the first edge.
  logic [31:0] sram [DEPTH];
  bit          sramReady = 1'b0;

  always @(posedge clk) begin
    if (!sramReady) begin
      for (int i = 0; i < DEPTH; i++) sram[i] = seedWord(i);
      sramReady = 1'b1;
    end
    if (bus.mem_en) begin
      if (bus.mem_we) sram[bus.mem_addr] = bus.mem_wdata;
      else            bus.mem_rdata <= sram[bus.mem_addr];
    end
  end

  // Reference model state: memory image, pending response, starvation count, last SRAM pins.
  logic [31:0] refMem [DEPTH];
  int          starve     = 0;
  bit          pendValid  = 1'b0;
  logic [31:0] pendInsn   = 32'h0;
  bit          pendErr    = 1'b0;
  logic [6:0]  lastAddr   = 7'h0;
  logic [31:0] lastWdata  = 32'h0;
  bit          addrKnown  = 1'b0;
  bit          wdataKnown = 1'b0;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input bit fv, input logic [63:0] pc, input bit fl,
                               input bit lv, input logic [6:0] la, input logic [31:0] ld);
    bit pcOk, full, ldWins, fetchWins;
    @(negedge clk);
    rst_n               = 1'b1;
    bus.fetch_req_valid = fv;
    bus.fetch_pc        = pc;
    bus.fetch_flush     = fl;
    bus.ld_valid        = lv;
    bus.ld_addr         = la;
    bus.ld_data         = ld;
    #1;
    pcOk      = (pc[1:0] == 2'b00) && (pc < 64'(4 * DEPTH));
    full      = (starve >= LIMIT);
    ldWins    = LOADER && lv && !(fv && full);
    fetchWins = fv && !ldWins;

    checkOutput("fetch_grant", 64'(bus.fetch_req_valid && bus.fetch_req_ready), 64'(fetchWins));
`ifdef IMEM_ARB_LOADER_EN
    checkOutput("ld_grant", 64'(bus.ld_valid && bus.ld_ready), 64'(ldWins));
`else
    checkOutput("fetch_ready", 64'(bus.fetch_req_ready), 64'd1);
    checkOutput("ld_ready", 64'(bus.ld_ready), 64'd0);
`endif
    checkOutput("mem_en", 64'(bus.mem_en), 64'(ldWins || (fetchWins && pcOk)));
    checkOutput("mem_we", 64'(bus.mem_we), 64'(ldWins));
    if (ldWins) begin
      checkOutput("mem_addr_ld", 64'(bus.mem_addr), 64'(la));
      checkOutput("mem_wdata_ld", 64'(bus.mem_wdata), 64'(ld));
    end else if (fetchWins && pcOk) begin
      checkOutput("mem_addr_fetch", 64'(bus.mem_addr), 64'(pc[8:2]));
    end else if (!fetchWins) begin
      if (addrKnown)  checkOutput("mem_addr_hold", 64'(bus.mem_addr), 64'(lastAddr));
      if (wdataKnown) checkOutput("mem_wdata_hold", 64'(bus.mem_wdata), 64'(lastWdata));
    end

    checkOutput("rsp_valid", 64'(bus.fetch_rsp_valid), 64'(pendValid && !fl));
    if (pendValid) begin
      checkOutput("rsp_insn", 64'(bus.fetch_rsp_insn), 64'(pendInsn));
      checkOutput("rsp_err", 64'(bus.fetch_rsp_err), 64'(pendErr));
    end

    if (ldWins) begin
      refMem[la] = ld;
      lastAddr   = la;
      lastWdata  = ld;
      addrKnown  = 1'b1;
      wdataKnown = 1'b1;
    end
    if (fetchWins) begin
      pendInsn   = pcOk ? refMem[int'(pc[8:2])] : 32'h00000013;
      pendErr    = !pcOk;
      wdataKnown = 1'b0;
      if (pcOk) begin
        lastAddr  = pc[8:2];
        addrKnown = 1'b1;
      end else begin
        addrKnown = 1'b0;
      end
    end
    pendValid = fetchWins;
    if (fetchWins || !fv)            starve = 0;
    else if (ldWins && starve < LIMIT) starve++;
  endtask

  task automatic applyReset(input bit fv, input bit lv);
    @(negedge clk);
    rst_n               = 1'b0;
    bus.fetch_req_valid = fv;
    bus.fetch_pc        = 64'h10;
    bus.fetch_flush     = 1'b0;
    bus.ld_valid        = lv;
    bus.ld_addr         = 7'd1;
    bus.ld_data         = 32'h1;
    #1;
    checkOutput("rst_fetch_ready", 64'(bus.fetch_req_ready), 64'd0);
    checkOutput("rst_ld_ready", 64'(bus.ld_ready), 64'd0);
    checkOutput("rst_mem_en", 64'(bus.mem_en), 64'd0);
    checkOutput("rst_mem_we", 64'(bus.mem_we), 64'd0);
    checkOutput("rst_rsp_valid", 64'(bus.fetch_rsp_valid), 64'd0);
    pendValid = 1'b0;
    starve    = 0;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 64'h0, 1'b0, 1'b0, 7'h0, 32'h0);
  endtask

  task automatic fetch(input logic [63:0] pc, input bit fl);
    applyStimulus(1'b1, pc, fl, 1'b0, 7'h0, 32'h0);
  endtask

  initial begin
    logic [63:0] rpc;
    int          sel;

    for (int i = 0; i < DEPTH; i++) refMem[i] = seedWord(i);
    bus.fetch_req_valid = 1'b0;
    bus.fetch_pc        = 64'h0;
    bus.fetch_flush     = 1'b0;
    bus.ld_valid        = 1'b0;
    bus.ld_addr         = 7'h0;
    bus.ld_data         = 32'h0;

    applyReset(1'b1, 1'b1);
    applyReset(1'b1, 1'b1);

    idle();
    checkOutput("post_rst_insn", 64'(bus.fetch_rsp_insn), 64'h0);
    checkOutput("post_rst_err", 64'(bus.fetch_rsp_err), 64'd0);
    checkOutput("post_rst_state", 64'(dut.state_q), 64'(IDLE));

    // Aligned fetch of the preloaded word 4.
    fetch(64'h10, 1'b0);
    idle();
    checkOutput("word4_insn", 64'(bus.fetch_rsp_insn), 64'hDEADBEEF);

    // Misaligned and out-of-range fetches respond with NOP and error.
    fetch(64'h6, 1'b0);
    fetch(64'h200, 1'b0);
    checkOutput("oor_insn_first", 64'(bus.fetch_rsp_insn), 64'h00000013);
    idle();
    checkOutput("oor_err_second", 64'(bus.fetch_rsp_err), 64'd1);

    for (int i = 0; i < 4; i++) fetch(64'(i * 4), 1'b0);
    idle();

    // Flush alone kills the response; flush with a new accept kills only the older one.
    fetch(64'h20, 1'b0);
    fetch(64'h0, 1'b1);
    checkOutput("flush_kill", 64'(bus.fetch_rsp_valid), 64'd0);
    idle();
    fetch(64'h24, 1'b0);
    fetch(64'h28, 1'b1);
    idle();
    checkOutput("flush_new_valid", 64'(bus.fetch_rsp_valid), 64'd1);
    checkOutput("flush_new_insn", 64'(bus.fetch_rsp_insn), 64'(seedWord(10)));

    // Reset landing on the response cycle drops the fetch.
    fetch(64'h30, 1'b0);
    applyReset(1'b0, 1'b0);
    idle();
    checkOutput("rsp_after_rst", 64'(bus.fetch_rsp_valid), 64'd0);
    checkOutput("state_after_rst", 64'(dut.state_q), 64'(IDLE));

`ifdef IMEM_ARB_LOADER_EN
    applyStimulus(1'b0, 64'h0, 1'b0, 1'b1, 7'd5, 32'h00500093);
    fetch(64'h14, 1'b0);
    idle();
    checkOutput("loaded_insn", 64'(bus.fetch_rsp_insn), 64'h00500093);

    // Both requestors always valid: four loader grants, then one fetch grant.
    for (int i = 0; i < 15; i++) begin
      applyStimulus(1'b1, 64'(($urandom % DEPTH) * 4), 1'b0, 1'b1,
                    7'($urandom), $urandom);
      checkOutput("starve_pattern", 64'(bus.fetch_req_ready), 64'((i % 5) == 4));
    end
    idle();
`else
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'($urandom), 64'(($urandom % DEPTH) * 4), 1'b0, 1'b1,
                    7'($urandom), $urandom);
      checkOutput("no_loader_we", 64'(bus.mem_we), 64'd0);
    end
    idle();
`endif

    for (int i = 0; i < 300; i++) begin
      sel = int'($urandom % 10);
      if (sel < 7)       rpc = 64'(($urandom % DEPTH) * 4);
      else if (sel == 7) rpc = 64'(($urandom % DEPTH) * 4 + ($urandom % 3) + 1);
      else if (sel == 8) rpc = 64'(4 * DEPTH + ($urandom % 64) * 4);
      else               rpc = {$urandom, $urandom};
      applyStimulus(($urandom % 4) != 0, rpc, ($urandom % 8) == 0,
                    1'($urandom), 7'($urandom), $urandom);
    end
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
